bft_leaf_arbiter: RTL and testbench
===================================

# bft_leaf_arbiter

Round-robin arbiter that shares one 49-bit BFT leaf port among several page operators. It sits between up to NUM_PAGES page output streams and the single `dout_leaf_interface2bft` leaf link of a PR region. It registers one winning packet per cycle, honours leaf backpressure, and follows an ap_start/halt run sequence.

## Interface
- NUM_PAGES, 4: number of requesting pages (2..8).
- PKT_W, 49: packet width; bit PKT_W-1 is the packet valid flag, bits PKT_W-2:0 are payload.
- clk, input, 1: sole clock, rising edge.
- reset, input, 1: asynchronous, active-high reset.
- ap_start, input, 1: single-cycle pulse that starts arbitration.
- halt, input, 1: level; stop granting and drain.
- din_page, input, NUM_PAGES*PKT_W: page i packet at bits [i*PKT_W +: PKT_W]; the request is its valid bit.
- page_ready, output, NUM_PAGES: one-hot accept strobe; page i's packet is consumed in any cycle where page_ready[i]=1.
- dout_leaf_interface2bft, output, PKT_W: registered packet to the BFT leaf.
- leaf_ready, input, 1: BFT accepts the output packet this cycle when its valid bit and leaf_ready are both 1.
- resend, input, 1: pulse; replays the last accepted packet (only with macro).
- busy, output, 1: high when not in IDLE.

## Operation
- States: IDLE, RUN, FLUSH. Reset → IDLE.
- IDLE: page_ready=0, no loads, output register held. ap_start=1 → RUN. halt takes priority over ap_start in the same cycle: stay IDLE.
- RUN: `load` = (output valid bit==0) or leaf_ready.
  - If load and at least one request, the winner is the first requesting index at or after `ptr`, searching cyclically.
  - The winner's packet goes into the output register, page_ready[winner]=1, and ptr ← (winner+1) mod NUM_PAGES.
  - If load and no request, the output register is loaded with 0 (valid cleared).
  - halt=1 → FLUSH; no grant is made in the cycle halt is sampled.
- FLUSH: no grants. When the output valid bit is 0, or leaf_ready=1, the output is cleared and the FSM goes to IDLE.
- ptr is NUM_PAGES-wide one-hot or log2 index (designer's choice). It survives IDLE and is cleared only by reset.
- page_ready is combinational from state, ptr, requests, output valid and leaf_ready. It never asserts for a page whose valid bit is 0.

## Timing
- Reset values:
  - dout_leaf_interface2bft=0, page_ready=0, busy=0.
  - ptr=0, state IDLE, replay register=0.
- Latency: a packet accepted at edge t (page_ready high in cycle t) is visible on dout from cycle t+1.
- Throughput: one packet per cycle while leaf_ready=1 and requests exist.
- Backpressure: while the output valid bit is 1 and leaf_ready=0, dout is held bit-exact and page_ready=0.
- busy rises the cycle after ap_start and falls the cycle after entering IDLE.
- Asserting reset mid-packet clears all state immediately. The packet in the output register is lost; the page is not re-granted.
- Wrap-around: with ptr=NUM_PAGES-1 and only page 0 requesting, page 0 wins and ptr becomes 1.

## Configuration
- BFT_LEAF_RESEND_EN defined:
  - Every packet accepted by the leaf (valid and leaf_ready) is copied into a replay register.
  - A resend pulse in RUN or FLUSH sets a pending flag.
  - At the next load, the replay register is loaded into dout instead of the arbitration winner. No page_ready is given and ptr is unchanged.
  - The pending flag then clears. A resend while a flag is already pending is absorbed; only one replay occurs.
- Undefined: no replay register and no pending flag exist; the resend input is ignored.

## Test plan
- Reset then idle: drive all four pages valid without ap_start → dout=0 and page_ready=0 for 20 cycles; busy=0.
- Round robin: ap_start, all four pages valid, leaf_ready=1 → page_ready sequence 0001,0010,0100,1000,0001; dout payloads match one cycle later.
- Backpressure: page 2 alone with payload 0x1234, leaf_ready=0 for 5 cycles → dout holds {1,0x1234}, page_ready=0; grant resumes the cycle after leaf_ready=1.
- Wrap/skip: ptr=3, only pages 0 and 1 requesting → page 0 granted, then page 1.
- Halt drain: halt while dout is valid and leaf_ready=0 → no grants. After one leaf_ready cycle, dout=0, state IDLE, busy falls next cycle.
- Resend (macro on): packet 0xABC accepted, then resend pulse → next dout = {1,0xABC} with page_ready=0; arbitration resumes from the unchanged ptr.

Source files
------------

// File: rtl/bft_leaf_arbiter.sv
// Round-robin arbiter sharing one registered BFT leaf port among NUM_PAGES page streams.
// Optional packet replay is compiled in with BFT_LEAF_RESEND_EN.
module bft_leaf_arbiter #(
    parameter int NUM_PAGES = 4,
    parameter int PKT_W     = 49
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       ap_start,
    input  logic                       halt,
    input  logic [NUM_PAGES*PKT_W-1:0] din_page,
    output logic [NUM_PAGES-1:0]       page_ready,
    output logic [PKT_W-1:0]           dout_leaf_interface2bft,
    input  logic                       leaf_ready,
    input  logic                       resend,
    output logic                       busy
);
    localparam int PW = (NUM_PAGES > 1) ? $clog2(NUM_PAGES) : 1;

    typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

    state_t               state, state_nxt;
    logic [PW-1:0]        ptr, ptr_nxt, win;
    logic [NUM_PAGES-1:0] req;
    logic                 found, out_vld, load, run_load, grant, take_replay, replay;
    logic [PKT_W-1:0]     dout_nxt, replay_q;

    assign out_vld  = dout_leaf_interface2bft[PKT_W-1];
    assign load     = !out_vld || leaf_ready;
    assign run_load = (state == RUN) && !halt && load;
    assign busy     = (state != IDLE);

    always_comb begin
        req = '0;
        for (int i = 0; i < NUM_PAGES; i++) req[i] = din_page[i*PKT_W + PKT_W-1];
    end

    // Cyclic search for the first request at or after ptr.
    always_comb begin : search
        int idx;
        idx   = 0;
        found = 1'b0;
        win   = '0;
        for (int k = 0; k < NUM_PAGES; k++) begin
            idx = int'(ptr) + k;
            if (idx >= NUM_PAGES) idx = idx - NUM_PAGES;
            if (!found && req[idx]) begin
                found = 1'b1;
                win   = PW'(idx);
            end
        end
    end

    assign take_replay = run_load && replay;
    assign grant       = run_load && !replay && found;
    assign page_ready  = grant ? (NUM_PAGES'(1) << win) : '0;

    always_comb begin
        ptr_nxt = ptr;
        if (grant) ptr_nxt = (win == PW'(NUM_PAGES-1)) ? '0 : win + 1'b1;
    end

    always_comb begin
        state_nxt = state;
        dout_nxt  = dout_leaf_interface2bft;
        case (state)
            IDLE: if (ap_start && !halt) state_nxt = RUN;
            RUN: begin
                if (halt) begin
                    state_nxt = FLUSH;
                    if (load) dout_nxt = '0;
                end else if (load) begin
                    if (take_replay) dout_nxt = replay_q;
                    else if (found)  dout_nxt = din_page[win*PKT_W +: PKT_W];
                    else             dout_nxt = '0;
                end
            end
            FLUSH: if (load) begin
                dout_nxt  = '0;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr                     <= '0;
            dout_leaf_interface2bft <= '0;
        end else begin
            ptr                     <= ptr_nxt;
            dout_leaf_interface2bft <= dout_nxt;
        end
    end

`ifdef BFT_LEAF_RESEND_EN
    logic pend;
    assign replay = pend;

    // Consumption clears the flag; a resend landing the same cycle is absorbed.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            replay_q <= '0;
            pend     <= 1'b0;
        end else begin
            if (out_vld && leaf_ready) replay_q <= dout_leaf_interface2bft;
            if (take_replay)                       pend <= 1'b0;
            else if (resend && state != IDLE)      pend <= 1'b1;
        end
    end
`else
    wire unused_resend = resend;
    assign replay   = 1'b0;
    assign replay_q = '0;
`endif

endmodule

// File: tb/tb_bft_leaf_arbiter.sv
// Scoreboard bench for bft_leaf_arbiter: expected leaf packets queued at grant, popped a cycle later.
module tb_bft_leaf_arbiter;
    localparam int N = 4;
    localparam int W = 49;

    logic           clk = 1'b0;
    logic           reset, ap_start, halt, leaf_ready, resend;
    logic [N*W-1:0] din_page;
    logic [N-1:0]   page_ready;
    logic [W-1:0]   dout;
    logic           busy;
    logic [W-1:0]   pg [N];
    logic [W-1:0]   exp_q [$];
    int             checks = 0;
    int             errors = 0;

    bft_leaf_arbiter #(.NUM_PAGES(N), .PKT_W(W)) dut (
        .clk(clk), .reset(reset), .ap_start(ap_start), .halt(halt),
        .din_page(din_page), .page_ready(page_ready),
        .dout_leaf_interface2bft(dout), .leaf_ready(leaf_ready),
        .resend(resend), .busy(busy)
    );

    always #5 clk = ~clk;

    always_comb begin
        din_page = '0;
        for (int i = 0; i < N; i++) din_page[i*W +: W] = pg[i];
    end

    function automatic logic [W-1:0] pkt(input logic [W-2:0] p);
        return {1'b1, p};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic sb_pop(input string tag);
        logic [W-1:0] e;
        chk({tag, "_qdepth"}, 64'(exp_q.size() > 0), 64'd1);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk(tag, 64'(dout), 64'(e));
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_pages();
        for (int i = 0; i < N; i++) pg[i] = '0;
    endtask

    initial begin
        reset = 1'b1; ap_start = 1'b0; halt = 1'b0; leaf_ready = 1'b1; resend = 1'b0;
        for (int i = 0; i < N; i++) pg[i] = pkt(49'h100 + 49'(i));
        #3;
        chk("rst_dout", 64'(dout), 64'd0);
        chk("rst_pr", 64'(page_ready), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        cyc(); cyc();
        reset = 1'b0;

        // Idle: requests present but no ap_start
        for (int c = 0; c < 20; c++) begin
            #2;
            chk("idle_dout", 64'(dout), 64'd0);
            chk("idle_pr", 64'(page_ready), 64'd0);
            chk("idle_busy", 64'(busy), 64'd0);
            cyc();
        end

        // Round robin with all pages requesting
        ap_start = 1'b1;
        cyc();
        ap_start = 1'b0;
        for (int k = 0; k < 5; k++) begin
            #2;
            chk("rr_pr", 64'(page_ready), 64'(1 << (k % N)));
            chk("rr_busy", 64'(busy), 64'd1);
            exp_q.push_back(pkt(49'h100 + 49'(k % N)));
            cyc();
            sb_pop("rr_dout");
        end

        // Backpressure on page 2 (ptr=1)
        clr_pages();
        pg[2] = pkt(49'h1234);
        #2;
        chk("bp_pr_first", 64'(page_ready), 64'b0100);
        exp_q.push_back(pkt(49'h1234));
        cyc();
        sb_pop("bp_dout_first");
        pg[2] = pkt(49'h5678);
        leaf_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            #2;
            chk("bp_pr_hold", 64'(page_ready), 64'd0);
            chk("bp_dout_hold", 64'(dout), 64'(pkt(49'h1234)));
            cyc();
        end
        leaf_ready = 1'b1;
        #2;
        chk("bp_pr_resume", 64'(page_ready), 64'b0100);
        exp_q.push_back(pkt(49'h5678));
        cyc();
        sb_pop("bp_dout_resume");

        // Wrap and skip: ptr=3, pages 0 and 1 requesting
        clr_pages();
        pg[0] = pkt(49'h10);
        pg[1] = pkt(49'h11);
        #2;
        chk("wrap_pr0", 64'(page_ready), 64'b0001);
        exp_q.push_back(pkt(49'h10));
        cyc();
        sb_pop("wrap_dout0");
        #2;
        chk("wrap_pr1", 64'(page_ready), 64'b0010);
        exp_q.push_back(pkt(49'h11));
        cyc();
        sb_pop("wrap_dout1");
        clr_pages();
        #2;
        chk("empty_pr", 64'(page_ready), 64'd0);
        cyc();
        chk("empty_dout", 64'(dout), 64'd0);

        // Halt drain (ptr=2)
        pg[3] = pkt(49'h33);
        #2;
        chk("halt_pr_pre", 64'(page_ready), 64'b1000);
        exp_q.push_back(pkt(49'h33));
        cyc();
        sb_pop("halt_dout_pre");
        clr_pages();
        pg[0] = pkt(49'h40);
        leaf_ready = 1'b0;
        halt = 1'b1;
        #2;
        chk("halt_pr_sample", 64'(page_ready), 64'd0);
        cyc();
        for (int c = 0; c < 2; c++) begin
            #2;
            chk("flush_pr", 64'(page_ready), 64'd0);
            chk("flush_dout", 64'(dout), 64'(pkt(49'h33)));
            chk("flush_busy", 64'(busy), 64'd1);
            cyc();
        end
        leaf_ready = 1'b1;
        #2;
        chk("flush_pr_ready", 64'(page_ready), 64'd0);
        cyc();
        chk("drain_dout", 64'(dout), 64'd0);
        chk("drain_busy", 64'(busy), 64'd0);
        ap_start = 1'b1;
        cyc();
        ap_start = 1'b0;
        #2;
        chk("halt_start_busy", 64'(busy), 64'd0);
        chk("halt_start_pr", 64'(page_ready), 64'd0);
        halt = 1'b0;
        cyc();
        #2;
        chk("idle2_busy", 64'(busy), 64'd0);
        chk("idle2_pr", 64'(page_ready), 64'd0);

        // Resend (ptr=0)
        clr_pages();
        pg[1] = pkt(49'hABC);
        ap_start = 1'b1;
        cyc();
        ap_start = 1'b0;
        #2;
        chk("rs_pr_grant", 64'(page_ready), 64'b0010);
        exp_q.push_back(pkt(49'hABC));
        cyc();
        sb_pop("rs_dout_grant");
        clr_pages();
        resend = 1'b1;
        #2;
        chk("rs_pr_pulse", 64'(page_ready), 64'd0);
        cyc();
        resend = 1'b0;
        chk("rs_dout_empty", 64'(dout), 64'd0);
        for (int i = 0; i < N; i++) pg[i] = pkt(49'h200 + 49'(i));
        #2;
`ifdef BFT_LEAF_RESEND_EN
        chk("rs_pr_replay", 64'(page_ready), 64'd0);
        exp_q.push_back(pkt(49'hABC));
        cyc();
        sb_pop("rs_dout_replay");
        #2;
`endif
        chk("rs_pr_after", 64'(page_ready), 64'b0100);
        exp_q.push_back(pkt(49'h202));
        cyc();
        sb_pop("rs_dout_after");

        // Reset mid-packet
        leaf_ready = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        chk("mrst_dout", 64'(dout), 64'd0);
        chk("mrst_busy", 64'(busy), 64'd0);
        chk("mrst_pr", 64'(page_ready), 64'd0);
        cyc();
        reset = 1'b0;
        ap_start = 1'b1;
        cyc();
        ap_start = 1'b0;
        leaf_ready = 1'b1;
        #2;
        chk("mrst_pr_ptr0", 64'(page_ready), 64'b0001);
        exp_q.push_back(pkt(49'h200));
        cyc();
        sb_pop("mrst_dout");

        chk("sb_drained", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
